// File: rtl/zx_kbd_pkg.sv
// Shared constants and types for the ZX Spectrum keyboard matrix.
package zx_kbd_pkg;

    localparam int unsigned NumRows = 8;
    localparam int unsigned NumCols = 5;
    localparam int unsigned NumPos  = NumRows * NumCols;
    localparam int unsigned NumVk   = 6;

    // One bit per matrix position, index = row * NumCols + col.
    typedef logic [NumPos-1:0] zx_pos_t;

    // Virtual keys: PC keys that press SHIFT plus one other matrix key.
    typedef enum logic [2:0] {
        VkBksp,
        VkEsc,
        VkLeft,
        VkDown,
        VkUp,
        VkRight
    } zx_vk_e;

    localparam logic [1:0] ModShift = 2'd0;
    localparam logic [1:0] ModCtrl  = 2'd1;
    localparam logic [1:0] ModAlt   = 2'd2;

    localparam logic [7:0] ScLShift = 8'h12;
    localparam logic [7:0] ScRShift = 8'h59;
    localparam logic [7:0] ScCtrl   = 8'h14;
    localparam logic [7:0] ScAlt    = 8'h11;
    localparam logic [7:0] ScBksp   = 8'h66;
    localparam logic [7:0] ScEsc    = 8'h76;
    localparam logic [7:0] ScLeft   = 8'h6B;
    localparam logic [7:0] ScDown   = 8'h72;
    localparam logic [7:0] ScUp     = 8'h75;
    localparam logic [7:0] ScRight  = 8'h74;

    // Non-extended scancode -> {hit, row, col} for real matrix keys.
    function automatic logic [6:0] sc_lookup(logic [7:0] code);
        logic [6:0] r;
        case (code)
            ScLShift, ScRShift: r = {1'b1, 3'd0, 3'd0};
            8'h1A: r = {1'b1, 3'd0, 3'd1};  // Z
            8'h22: r = {1'b1, 3'd0, 3'd2};  // X
            8'h21: r = {1'b1, 3'd0, 3'd3};  // C
            8'h2A: r = {1'b1, 3'd0, 3'd4};  // V
            8'h1C: r = {1'b1, 3'd1, 3'd0};  // A
            8'h1B: r = {1'b1, 3'd1, 3'd1};  // S
            8'h23: r = {1'b1, 3'd1, 3'd2};  // D
            8'h2B: r = {1'b1, 3'd1, 3'd3};  // F
            8'h34: r = {1'b1, 3'd1, 3'd4};  // G
            8'h15: r = {1'b1, 3'd2, 3'd0};  // Q
            8'h1D: r = {1'b1, 3'd2, 3'd1};  // W
            8'h24: r = {1'b1, 3'd2, 3'd2};  // E
            8'h2D: r = {1'b1, 3'd2, 3'd3};  // R
            8'h2C: r = {1'b1, 3'd2, 3'd4};  // T
            8'h16: r = {1'b1, 3'd3, 3'd0};  // 1
            8'h1E: r = {1'b1, 3'd3, 3'd1};  // 2
            8'h26: r = {1'b1, 3'd3, 3'd2};  // 3
            8'h25: r = {1'b1, 3'd3, 3'd3};  // 4
            8'h2E: r = {1'b1, 3'd3, 3'd4};  // 5
            8'h45: r = {1'b1, 3'd4, 3'd0};  // 0
            8'h46: r = {1'b1, 3'd4, 3'd1};  // 9
            8'h3E: r = {1'b1, 3'd4, 3'd2};  // 8
            8'h3D: r = {1'b1, 3'd4, 3'd3};  // 7
            8'h36: r = {1'b1, 3'd4, 3'd4};  // 6
            8'h4D: r = {1'b1, 3'd5, 3'd0};  // P
            8'h44: r = {1'b1, 3'd5, 3'd1};  // O
            8'h43: r = {1'b1, 3'd5, 3'd2};  // I
            8'h3C: r = {1'b1, 3'd5, 3'd3};  // U
            8'h35: r = {1'b1, 3'd5, 3'd4};  // Y
            8'h5A: r = {1'b1, 3'd6, 3'd0};  // ENTER
            8'h4B: r = {1'b1, 3'd6, 3'd1};  // L
            8'h42: r = {1'b1, 3'd6, 3'd2};  // K
            8'h3B: r = {1'b1, 3'd6, 3'd3};  // J
            8'h33: r = {1'b1, 3'd6, 3'd4};  // H
            8'h29: r = {1'b1, 3'd7, 3'd0};  // SPACE
            8'h49: r = {1'b1, 3'd7, 3'd1};  // .
            8'h3A: r = {1'b1, 3'd7, 3'd2};  // M
            8'h31: r = {1'b1, 3'd7, 3'd3};  // N
            8'h32: r = {1'b1, 3'd7, 3'd4};  // B
            default: r = '0;
        endcase
        return r;
    endfunction

    // Matrix position of the non-shift half of each virtual key.
    function automatic logic [5:0] vk_pos(logic [2:0] vk);
        logic [5:0] p;
        case (vk)
            VkBksp:  p = 6'd20;  // 0
            VkEsc:   p = 6'd15;  // 1
            VkLeft:  p = 6'd19;  // 5
            VkDown:  p = 6'd24;  // 6
            VkUp:    p = 6'd23;  // 7
            VkRight: p = 6'd22;  // 8
            default: p = 6'd0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/zx_kbd_decode.sv
// Combinational PS/2 scancode classifier: matrix key, virtual key, Fn key, modifier.
module zx_kbd_decode
    import zx_kbd_pkg::*;
(
    input  logic       ext_i,
    input  logic [7:0] scancode_i,
    output logic       valid_o,
    output logic [2:0] row_o,
    output logic [2:0] col_o,
    output logic       virt_o,
    output logic [2:0] vk_o,
    output logic       fn_valid_o,
    output logic [3:0] fn_idx_o,
    output logic       mod_valid_o,
    output logic [1:0] mod_idx_o
);

    logic [6:0] lut;

    // Classify the event; every output defaults to "not mapped".
    always_comb begin
        lut         = sc_lookup(scancode_i);
        valid_o     = 1'b0;
        row_o       = 3'd0;
        col_o       = 3'd0;
        virt_o      = 1'b0;
        vk_o        = VkBksp;
        fn_valid_o  = 1'b0;
        fn_idx_o    = 4'd0;
        mod_valid_o = 1'b0;
        mod_idx_o   = 2'd0;
        if (!ext_i) begin
            valid_o = lut[6];
            row_o   = lut[5:3];
            col_o   = lut[2:0];
            case (scancode_i)
                ScBksp: begin valid_o = 1'b1; virt_o = 1'b1; vk_o = VkBksp; end
                ScEsc:  begin valid_o = 1'b1; virt_o = 1'b1; vk_o = VkEsc;  end
                ScLShift, ScRShift: begin mod_valid_o = 1'b1; mod_idx_o = ModShift; end
                8'h05: fn_idx_o = 4'd1;
                8'h06: fn_idx_o = 4'd2;
                8'h04: fn_idx_o = 4'd3;
                8'h0C: fn_idx_o = 4'd4;
                8'h03: fn_idx_o = 4'd5;
                8'h0B: fn_idx_o = 4'd6;
                8'h83: fn_idx_o = 4'd7;
                8'h0A: fn_idx_o = 4'd8;
                8'h01: fn_idx_o = 4'd9;
                8'h09: fn_idx_o = 4'd10;
                8'h78: fn_idx_o = 4'd11;
                default: ;
            endcase
            fn_valid_o = (fn_idx_o != 4'd0);
        end else begin
            case (scancode_i)
                ScLeft:  begin valid_o = 1'b1; virt_o = 1'b1; vk_o = VkLeft;  end
                ScDown:  begin valid_o = 1'b1; virt_o = 1'b1; vk_o = VkDown;  end
                ScUp:    begin valid_o = 1'b1; virt_o = 1'b1; vk_o = VkUp;    end
                ScRight: begin valid_o = 1'b1; virt_o = 1'b1; vk_o = VkRight; end
                default: ;
            endcase
        end
        // Left and right ctrl/alt share a code; E0 marks the right-hand one.
        if (scancode_i == ScCtrl) begin
            mod_valid_o = 1'b1;
            mod_idx_o   = ModCtrl;
        end else if (scancode_i == ScAlt) begin
            mod_valid_o = 1'b1;
            mod_idx_o   = ModAlt;
        end
    end

endmodule

// File: rtl/zx_kbd_matrix.sv
// PS/2 event stream to ZX Spectrum 8x5 keyboard matrix with minimum key hold time.
module zx_kbd_matrix
    import zx_kbd_pkg::*;
#(
    parameter int unsigned MIN_HOLD = 1_048_576
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [15:0] addr,
    output logic [4:0]  key_data,
    output logic [11:1] Fn,
    output logic [2:0]  mod
);

    localparam int unsigned TimerW = $clog2(MIN_HOLD + 1);

    logic              tog_q, tog_d;
    logic              ev_q, ev_d;
    logic [9:0]        ev_key_q, ev_key_d;
    zx_pos_t           real_q, real_d;
    zx_pos_t           pend_real_q, pend_real_d;
    logic [NumVk-1:0]  virt_q, virt_d;
    logic [NumVk-1:0]  pend_virt_q, pend_virt_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [11:1]       fn_q, fn_d;
    logic [2:0]        mod_q, mod_d;

    logic       dec_valid, dec_virt, dec_fn_valid, dec_mod_valid;
    logic [2:0] dec_row, dec_col, dec_vk;
    logic [3:0] dec_fn_idx;
    logic [1:0] dec_mod_idx;

    logic       press;
    logic       hold;
    logic [5:0] pos_idx;
    zx_pos_t    pos_oh;
    logic [NumVk-1:0] vk_oh;
    zx_pos_t    mat;
    logic [4:0] col_or;

    zx_kbd_decode u_decode (
        .ext_i       (ev_key_q[8]),
        .scancode_i  (ev_key_q[7:0]),
        .valid_o     (dec_valid),
        .row_o       (dec_row),
        .col_o       (dec_col),
        .virt_o      (dec_virt),
        .vk_o        (dec_vk),
        .fn_valid_o  (dec_fn_valid),
        .fn_idx_o    (dec_fn_idx),
        .mod_valid_o (dec_mod_valid),
        .mod_idx_o   (dec_mod_idx)
    );

    assign press   = ev_key_q[9];
    // A timer of 1 expires on this edge, and expiry is applied before the event.
    assign hold    = (timer_q > TimerW'(1));
    assign pos_idx = 6'(dec_row) * 6'd5 + 6'(dec_col);
    assign pos_oh  = zx_pos_t'(1) << pos_idx;
    assign vk_oh   = NumVk'(1) << dec_vk;

    // Next state: event capture, hold timer expiry, then the captured event.
    always_comb begin
        tog_d       = ps2_key[10];
        ev_d        = ps2_key[10] ^ tog_q;
        ev_key_d    = ps2_key[9:0];
        real_d      = real_q;
        virt_d      = virt_q;
        pend_real_d = pend_real_q;
        pend_virt_d = pend_virt_q;
        timer_d     = timer_q;
        fn_d        = fn_q;
        mod_d       = mod_q;

        if (timer_q != '0) begin
            timer_d = timer_q - TimerW'(1);
        end
        if (timer_q == TimerW'(1)) begin
            real_d      = real_d & ~pend_real_q;
            virt_d      = virt_d & ~pend_virt_q;
            pend_real_d = '0;
            pend_virt_d = '0;
        end

        if (ev_q) begin
            if (dec_valid) begin
                if (press) begin
                    timer_d = TimerW'(MIN_HOLD);
                    if (dec_virt) begin
                        virt_d      = virt_d | vk_oh;
                        pend_virt_d = pend_virt_d & ~vk_oh;
                    end else begin
                        real_d      = real_d | pos_oh;
                        pend_real_d = pend_real_d & ~pos_oh;
                    end
                end else if (hold) begin
                    if (dec_virt) pend_virt_d = pend_virt_d | vk_oh;
                    else          pend_real_d = pend_real_d | pos_oh;
                end else begin
                    if (dec_virt) virt_d = virt_d & ~vk_oh;
                    else          real_d = real_d & ~pos_oh;
                end
            end
            for (int i = 1; i <= 11; i++) begin
                if (dec_fn_valid && dec_fn_idx == 4'(i)) fn_d[i] = press;
            end
            if (dec_mod_valid) mod_d[dec_mod_idx] = press;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            tog_q       <= ps2_key[10];
            ev_q        <= 1'b0;
            ev_key_q    <= '0;
            real_q      <= '0;
            virt_q      <= '0;
            pend_real_q <= '0;
            pend_virt_q <= '0;
            timer_q     <= '0;
            fn_q        <= '0;
            mod_q       <= '0;
        end else begin
            tog_q       <= tog_d;
            ev_q        <= ev_d;
            ev_key_q    <= ev_key_d;
            real_q      <= real_d;
            virt_q      <= virt_d;
            pend_real_q <= pend_real_d;
            pend_virt_q <= pend_virt_d;
            timer_q     <= timer_d;
            fn_q        <= fn_d;
            mod_q       <= mod_d;
        end
    end

    // Visible matrix: real keys, virtual keys' own positions, and SHIFT for any virtual key.
    always_comb begin
        mat = real_q;
        for (int i = 0; i < NumVk; i++) begin
            if (virt_q[i]) mat[vk_pos(3'(i))] = 1'b1;
        end
        if (|virt_q) mat[0] = 1'b1;
    end

    // Column read-out: OR of every row whose select line is low, inverted.
    always_comb begin
        col_or = '0;
        for (int r = 0; r < NumRows; r++) begin
            if (!addr[8+r]) col_or = col_or | mat[r*NumCols +: NumCols];
        end
        key_data = ~col_or;
    end

    assign Fn  = fn_q;
    assign mod = mod_q;

endmodule

// File: tb/tb_zx_kbd_matrix.sv
// Bench for zx_kbd_matrix: directed vector table, reset sequence, randomized model check.
module tb_zx_kbd_matrix;

    localparam int unsigned MinHold = 16;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic [10:0] ps2_key = '0;
    logic [15:0] addr    = '0;
    logic [4:0]  key_data;
    logic [11:1] fn;
    logic [2:0]  mod;

    int checks = 0;
    int errors = 0;
    logic tog = 1'b0;

    always #5 clk_sys = ~clk_sys;

    zx_kbd_matrix #(
        .MIN_HOLD (MinHold)
    ) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ps2_key  (ps2_key),
        .addr     (addr),
        .key_data (key_data),
        .Fn       (fn),
        .mod      (mod)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input bit press, input bit ext, input logic [7:0] code);
        tog     = ~tog;
        ps2_key = {tog, press, ext, code};
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         ev;
        bit         press;
        bit         ext;
        logic [7:0] code;
        int         wait_n;
        logic [15:0] a;
        logic [4:0] kd;
        logic [2:0] md;
        logic [10:0] fv;
    } vec_t;
    vec_t vecs[$];

    task automatic add_v(input bit ev, input bit pr, input bit ext, input logic [7:0] code,
                         input int w, input logic [15:0] a, input logic [4:0] kd,
                         input logic [2:0] md, input logic [10:0] fv);
        vec_t t;
        t.ev = ev; t.press = pr; t.ext = ext; t.code = code; t.wait_n = w;
        t.a = a; t.kd = kd; t.md = md; t.fv = fv;
        vecs.push_back(t);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit         ext;
        logic [7:0] code;
        int         pos;   // matrix position, -1 if none
        bit         virt;  // also asserts SHIFT
        int         fnn;   // Fn number, 0 if none
        int         md;    // mod bit, -1 if none
    } key_t;
    key_t keys[$];
    bit down[32];   // physically held (Fn/mod follow this directly)
    bit mheld[32];  // asserted in the matrix
    bit pend[32];   // release waiting for hold time
    int m_timer;

    task automatic addk(input bit ext, input logic [7:0] code, input int pos, input bit virt,
                        input int fnn, input int md);
        key_t k;
        k.ext = ext; k.code = code; k.pos = pos; k.virt = virt; k.fnn = fnn; k.md = md;
        keys.push_back(k);
    endtask

    task automatic model_reset();
        for (int j = 0; j < 32; j++) begin
            down[j] = 0; mheld[j] = 0; pend[j] = 0;
        end
        m_timer = 0;
    endtask

    // One clock edge: hold time elapses first, then the event (if any).
    task automatic model_step(input bit v, input int k, input bit press);
        int old;
        old = m_timer;
        if (m_timer > 0) m_timer--;
        if (old == 1) begin
            for (int j = 0; j < 32; j++) begin
                if (pend[j]) begin mheld[j] = 0; pend[j] = 0; end
            end
        end
        if (v) begin
            down[k] = press;
            if (keys[k].pos >= 0) begin
                if (press) begin
                    mheld[k] = 1; pend[k] = 0; m_timer = MinHold;
                end else if (m_timer != 0) begin
                    pend[k] = 1;
                end else begin
                    mheld[k] = 0;
                end
            end
        end
    endtask

    function automatic logic [4:0] exp_kd(input logic [15:0] a);
        bit m[40];
        logic [4:0] kd;
        kd = 5'h1F;
        for (int p = 0; p < 40; p++) m[p] = 0;
        foreach (keys[j]) begin
            if (mheld[j] && keys[j].pos >= 0) begin
                m[keys[j].pos] = 1;
                if (keys[j].virt) m[0] = 1;
            end
        end
        for (int r = 0; r < 8; r++)
            for (int b = 0; b < 5; b++)
                if (!a[8+r] && m[r*5+b]) kd[b] = 1'b0;
        return kd;
    endfunction

    function automatic logic [11:1] exp_fn();
        logic [11:1] f;
        f = '0;
        foreach (keys[j]) if (down[j] && keys[j].fnn > 0) f[keys[j].fnn] = 1'b1;
        return f;
    endfunction

    function automatic logic [2:0] exp_mod();
        logic [2:0] m;
        m = '0;
        foreach (keys[j]) if (down[j] && keys[j].md >= 0) m[keys[j].md] = 1'b1;
        return m;
    endfunction

    initial begin
        int k;
        bit pr;
        bit st_v;
        int st_k;
        bit st_p;
        int rate;

        // Reset, with an event toggled while reset is asserted.
        wait_neg(3);
        send(1, 0, 8'h1C);
        wait_neg(1);
        reset = 1'b0;

        //     ev pr ex code  wait addr      kd     mod     Fn
        add_v(0, 0, 0, 8'h00, 3,  16'h0000, 5'h1F, 3'b000, 11'h000);
        add_v(1, 1, 0, 8'h1C, 2,  16'hFD00, 5'h1E, 3'b000, 11'h000);
        add_v(0, 0, 0, 8'h00, 0,  16'hFE00, 5'h1F, 3'b000, 11'h000);
        add_v(1, 0, 0, 8'h1C, 2,  16'hFD00, 5'h1E, 3'b000, 11'h000);
        add_v(0, 0, 0, 8'h00, 20, 16'hFD00, 5'h1F, 3'b000, 11'h000);
        add_v(1, 1, 1, 8'h6B, 2,  16'hF600, 5'h0E, 3'b000, 11'h000);
        add_v(0, 0, 0, 8'h00, 20, 16'hF600, 5'h0E, 3'b000, 11'h000);
        add_v(1, 0, 1, 8'h6B, 2,  16'hF600, 5'h1F, 3'b000, 11'h000);
        add_v(1, 1, 0, 8'h1A, 3,  16'hFE00, 5'h1D, 3'b000, 11'h000);
        add_v(1, 0, 0, 8'h1A, 2,  16'hFE00, 5'h1D, 3'b000, 11'h000);
        add_v(0, 0, 0, 8'h00, 12, 16'hFE00, 5'h1D, 3'b000, 11'h000);
        add_v(0, 0, 0, 8'h00, 1,  16'hFE00, 5'h1F, 3'b000, 11'h000);
        add_v(1, 1, 0, 8'h12, 2,  16'hFE00, 5'h1E, 3'b001, 11'h000);
        add_v(1, 1, 0, 8'h66, 2,  16'hEF00, 5'h1E, 3'b001, 11'h000);
        add_v(1, 0, 0, 8'h66, 2,  16'hEF00, 5'h1E, 3'b001, 11'h000);
        add_v(0, 0, 0, 8'h00, 20, 16'hEF00, 5'h1F, 3'b001, 11'h000);
        add_v(0, 0, 0, 8'h00, 0,  16'hFE00, 5'h1E, 3'b001, 11'h000);
        add_v(1, 0, 0, 8'h12, 2,  16'hFE00, 5'h1F, 3'b000, 11'h000);
        add_v(1, 1, 0, 8'h14, 2,  16'h0000, 5'h1F, 3'b010, 11'h000);
        add_v(1, 1, 0, 8'h78, 2,  16'h0000, 5'h1F, 3'b010, 11'h400);
        add_v(1, 1, 0, 8'h1C, 2,  16'hFD00, 5'h1E, 3'b010, 11'h400);
        add_v(1, 0, 0, 8'h78, 2,  16'hFD00, 5'h1E, 3'b010, 11'h000);
        add_v(1, 0, 0, 8'h14, 2,  16'hFD00, 5'h1E, 3'b000, 11'h000);
        add_v(1, 0, 0, 8'h1C, 2,  16'hFD00, 5'h1E, 3'b000, 11'h000);
        add_v(0, 0, 0, 8'h00, 20, 16'hFD00, 5'h1F, 3'b000, 11'h000);
        add_v(1, 1, 0, 8'h1C, 2,  16'hFD00, 5'h1E, 3'b000, 11'h000);
        add_v(1, 0, 0, 8'h1C, 2,  16'hFD00, 5'h1E, 3'b000, 11'h000);
        add_v(1, 1, 0, 8'h1C, 2,  16'hFD00, 5'h1E, 3'b000, 11'h000);
        add_v(0, 0, 0, 8'h00, 20, 16'hFD00, 5'h1E, 3'b000, 11'h000);
        add_v(1, 0, 0, 8'h1C, 2,  16'hFD00, 5'h1F, 3'b000, 11'h000);
        add_v(1, 1, 0, 8'h16, 2,  16'hF700, 5'h1E, 3'b000, 11'h000);
        add_v(1, 1, 0, 8'h76, 2,  16'hFE00, 5'h1E, 3'b000, 11'h000);
        add_v(1, 0, 0, 8'h76, 22, 16'hFE00, 5'h1F, 3'b000, 11'h000);
        add_v(0, 0, 0, 8'h00, 0,  16'hF700, 5'h1E, 3'b000, 11'h000);
        add_v(1, 0, 0, 8'h16, 2,  16'hF700, 5'h1F, 3'b000, 11'h000);
        add_v(1, 1, 0, 8'h0E, 2,  16'h0000, 5'h1F, 3'b000, 11'h000);
        add_v(1, 1, 1, 8'h1C, 2,  16'h0000, 5'h1F, 3'b000, 11'h000);

        foreach (vecs[i]) begin
            if (vecs[i].ev) send(vecs[i].press, vecs[i].ext, vecs[i].code);
            wait_neg(vecs[i].wait_n);
            addr = vecs[i].a;
            #1;
            check($sformatf("vec%0d key_data", i), 32'(key_data), 32'(vecs[i].kd));
            check($sformatf("vec%0d mod", i), 32'(mod), 32'(vecs[i].md));
            check($sformatf("vec%0d Fn", i), 32'(fn), 32'(vecs[i].fv));
        end

        // Reset during a hold discards the pending release; events resume right after.
        send(1, 0, 8'h1A);
        wait_neg(2);
        send(0, 0, 8'h1A);
        wait_neg(2);
        addr = 16'hFE00; #1;
        check("midhold pending", 32'(key_data), 32'h1D);
        reset = 1'b1;
        wait_neg(1);
        #1;
        check("midhold reset kd", 32'(key_data), 32'h1F);
        addr = 16'h0000; #1;
        check("midhold reset all rows", 32'(key_data), 32'h1F);
        reset = 1'b0;
        send(1, 0, 8'h1C);
        wait_neg(2);
        addr = 16'hFD00; #1;
        check("resume first cycle", 32'(key_data), 32'h1E);
        wait_neg(20);
        addr = 16'hFE00; #1;
        check("no resurrected Z", 32'(key_data), 32'h1F);

        // Randomized phase against the model.
        addk(0, 8'h1C, 5, 0, 0, -1);  addk(0, 8'h1A, 1, 0, 0, -1);
        addk(0, 8'h16, 15, 0, 0, -1); addk(0, 8'h45, 20, 0, 0, -1);
        addk(0, 8'h2E, 19, 0, 0, -1); addk(0, 8'h36, 24, 0, 0, -1);
        addk(0, 8'h3E, 22, 0, 0, -1); addk(0, 8'h29, 35, 0, 0, -1);
        addk(0, 8'h32, 39, 0, 0, -1); addk(0, 8'h5A, 30, 0, 0, -1);
        addk(0, 8'h12, 0, 0, 0, 0);
        addk(0, 8'h66, 20, 1, 0, -1); addk(0, 8'h76, 15, 1, 0, -1);
        addk(1, 8'h6B, 19, 1, 0, -1); addk(1, 8'h72, 24, 1, 0, -1);
        addk(1, 8'h75, 23, 1, 0, -1); addk(1, 8'h74, 22, 1, 0, -1);
        addk(0, 8'h05, -1, 0, 1, -1); addk(0, 8'h83, -1, 0, 7, -1);
        addk(0, 8'h78, -1, 0, 11, -1); addk(0, 8'h01, -1, 0, 9, -1);
        addk(0, 8'h14, -1, 0, 0, 1);  addk(0, 8'h11, -1, 0, 0, 2);
        addk(0, 8'h0E, -1, 0, 0, -1); addk(1, 8'h1C, -1, 0, 0, -1);
        addk(0, 8'h7C, -1, 0, 0, -1); addk(1, 8'h05, -1, 0, 0, -1);

        reset = 1'b1;
        wait_neg(2);
        reset = 1'b0;
        model_reset();
        st_v = 0; st_k = 0; st_p = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            addr = 16'($urandom);
            #1;
            check("rand key_data", 32'(key_data), 32'(exp_kd(addr)));
            check("rand Fn", 32'(fn), 32'(exp_fn()));
            check("rand mod", 32'(mod), 32'(exp_mod()));
            model_step(st_v, st_k, st_p);
            st_v = 0;
            rate = ((cyc / 200) % 2 == 0) ? 2 : 10;
            if ($urandom_range(0, rate - 1) == 0) begin
                k  = $urandom_range(0, keys.size() - 1);
                pr = ($urandom_range(0, 9) < 6);
                send(pr, keys[k].ext, keys[k].code);
                st_v = 1; st_k = k; st_p = pr;
            end
            wait_neg(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
